// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with TX FIFO, runtime baud divisor and runtime frame format.
// Frame settings are latched per frame on pop; frames run back-to-back while data is queued.
module uart_tx_fifo_cfg #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 5208
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          div_load,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_next;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_m1;

    state_t               state_q,    state_d;
    logic [DIV_WIDTH-1:0] cnt_q,      cnt_d;
    logic [DIV_WIDTH-1:0] dm1_q,      dm1_d;
    logic [7:0]           shift_q,    shift_d;
    logic [2:0]           idx_q,      idx_d;
    logic [2:0]           last_q,     last_d;
    logic                 par_q,      par_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_odd_q,  par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic                 half_q,     half_d;
    logic                 tx_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 bit_end;

    assign push       = data_valid && data_ready;
    assign fifo_empty = (fifo_count == '0);
    assign div_m1     = (div_q == '0) ? '0 : DIV_WIDTH'(div_q - DIV_WIDTH'(1));
    assign bit_end    = (cnt_q == '0);

    // FIFO occupancy; pop is never issued when empty and push is gated by data_ready
    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = CW'(fifo_count + CW'(1));
            2'b01:   count_next = CW'(fifo_count - CW'(1));
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= AW'(wr_ptr + AW'(1));
            if (pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
            fifo_count <= count_next;
            data_ready <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           div_q <= DIV_WIDTH'(DEFAULT_DIV);
        else if (div_load) div_q <= baud_div;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm1_d      = dm1_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        last_d     = last_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        half_d     = half_q;
        tx_d       = tx;
        busy_d     = busy;
        pop        = 1'b0;

        if (state_q != S_IDLE && !bit_end) cnt_d = DIV_WIDTH'(cnt_q - DIV_WIDTH'(1));

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = dm1_q;
                    tx_d    = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = dm1_q;
                    if (idx_q == last_q) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_q ^ par_odd_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            half_d  = 1'b0;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = 3'(idx_q + 3'd1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = dm1_q;
                    tx_d    = 1'b1;
                    half_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !half_q) begin
                        cnt_d  = dm1_q;
                        half_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: latch data and format so mid-frame input changes only hit the next frame
        if (pop) begin
            state_d    = S_START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            shift_d    = mem[rd_ptr];
            par_d      = 1'b0;
            cnt_d      = div_m1;
            dm1_d      = div_m1;
            last_d     = 3'(3'd4 + 3'(data_bits));
            par_en_d   = ^parity_mode;
            par_odd_d  = (parity_mode == 2'b10);
            two_stop_d = stop_bits;
            half_d     = 1'b0;
        end

        done_d = (state_d == S_STOP) && (cnt_d == '0) && (!two_stop_q || half_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dm1_q      <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            half_q     <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm1_q      <= dm1_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            half_q     <= half_d;
            tx         <= tx_d;
            busy       <= busy_d;
            tx_done    <= done_d;
        end
    end

endmodule
